// File: rtl/if_stage_if.sv
// IF stage bus: stall/redirect controls, imem port and IF/ID outputs.
// master = fetch stage, slave = hazard unit / imem / ID side.
interface if_stage_if;
  logic        i_stall;
  logic        i_brTaken;
  logic [15:0] i_brTarget;
  logic        i_jmp;
  logic [15:0] i_jmpTarget;
  logic [15:0] o_imAddr;
  logic [15:0] i_imData;
  logic [15:0] o_instr;
  logic [15:0] o_pc;
  logic        o_valid;
  logic        o_halted;
  logic [15:0] o_fetchCnt;

  modport master (
    input  i_stall, i_brTaken, i_brTarget,
    input  i_jmp, i_jmpTarget, i_imData,
    output o_imAddr, o_instr, o_pc,
    output o_valid, o_halted, o_fetchCnt
  );

  modport slave (
    output i_stall, i_brTaken, i_brTarget,
    output i_jmp, i_jmpTarget, i_imData,
    input  o_imAddr, o_instr, o_pc,
    input  o_valid, o_halted, o_fetchCnt
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch: owns PC, IF/ID register, stall/flush/halt.
// Ports: i_clk, i_nRst (async low), bus (if_stage_if.master).
module if_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [3:0]  HLT_OP    = 4'hF,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input logic         i_clk,
  input logic         i_nRst,
  if_stage_if.master  bus
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t      state, state_n;
  logic [15:0] pc, pc_n;
  logic [15:0] instr, instr_n;
  logic [15:0] opc, opc_n;
  logic [15:0] cnt, cnt_n;
  logic        valid, valid_n;

  logic        redirect;
  logic [15:0] target;
  logic [15:0] pc_inc;
  logic        is_hlt;
  logic        hold;
  logic        idle;

  // Branch is the older instruction, so it wins over a jump.
  assign redirect = bus.i_brTaken | bus.i_jmp;
  assign target   = bus.i_brTaken ? bus.i_brTarget
                                  : bus.i_jmpTarget;
  assign pc_inc   = pc + 16'd1;
  assign is_hlt   = bus.i_imData[15:12] == HLT_OP;
  assign hold     = !redirect && bus.i_stall;
  assign idle     = !redirect && !bus.i_stall
                    && state == HALTED;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    instr_n = instr;
    opc_n   = opc;
    valid_n = valid;
    cnt_n   = cnt;
    unique case (1'b1)
      redirect: begin
        pc_n    = target;
        instr_n = NOP_INSTR;
        valid_n = 1'b0;
        state_n = RUN;
      end
      hold: begin
        state_n = state;
      end
      idle: begin
        instr_n = NOP_INSTR;
        valid_n = 1'b0;
      end
      default: begin
        instr_n = bus.i_imData;
        opc_n   = pc_inc;
        valid_n = 1'b1;
        cnt_n   = cnt + 16'd1;
        // HLT goes to ID but PC parks on it.
        if (is_hlt) state_n = HALTED;
        else        pc_n    = pc_inc;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nRst) begin
    if (!i_nRst) begin
      state <= RUN;
      pc    <= RESET_PC;
      instr <= NOP_INSTR;
      opc   <= 16'h0000;
      valid <= 1'b0;
      cnt   <= 16'h0000;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      instr <= instr_n;
      opc   <= opc_n;
      valid <= valid_n;
      cnt   <= cnt_n;
    end
  end

  assign bus.o_imAddr   = pc;
  assign bus.o_instr    = instr;
  assign bus.o_pc       = opc;
  assign bus.o_valid    = valid;
  assign bus.o_halted   = state == HALTED;
  assign bus.o_fetchCnt = cnt;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 16-bit pipelined core; sits directly upstream of ID.
- Owns the PC, drives the instruction-memory read address and holds the IF/ID pipeline register.
- Handles hazard-unit stall, branch/jump redirect flush and halt detection.
- Outputs o_instr and o_pc feed ID's i_instr and i_pc.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- HLT_OP, 4'hF, opcode (instr[15:12]) that halts fetch.
- NOP_INSTR, 16'h0000, bubble instruction inserted on flush or after halt.

Ports:
- i_clk  in  1  clock, rising edge.
- i_nRst  in  1  asynchronous active-low reset.
- i_stall  in  1  hazard unit: hold PC and IF/ID this cycle.
- i_brTaken  in  1  resolved taken branch; redirect to i_brTarget.
- i_brTarget  in  16  branch target address.
- i_jmp  in  1  jump resolved; redirect to i_jmpTarget.
- i_jmpTarget  in  16  jump target address.
- o_imAddr  out  16  instruction-memory address, equals PC.
- i_imData  in  16  instruction memory read data; combinational, valid in the same cycle as o_imAddr.
- o_instr  out  16  IF/ID instruction to ID.
- o_pc  out  16  IF/ID PC+1 of o_instr, used as branch base.
- o_valid  out  1  o_instr is a real fetched instruction, not a bubble.
- o_halted  out  1  fetch has stopped on HLT.
- o_fetchCnt  out  16  count of valid instructions delivered to ID.

Behaviour:
- Reset (async, i_nRst=0), all of the following apply immediately:
  - PC=RESET_PC, o_instr=NOP_INSTR, o_pc=0, o_valid=0, o_halted=0, o_fetchCnt=0.
  - FSM=RUN.
  - Reset mid-operation discards everything, including the HALTED state.
- Word-addressed; PC+1 wraps 16'hFFFF->16'h0000 with no flag.
- Per-edge priority: redirect > stall > halt > normal.
- Redirect is i_brTaken|i_jmp. If both are asserted, i_brTaken wins because the branch is the older instruction.
  - On redirect: PC<=target, o_instr<=NOP_INSTR, o_valid<=0, FSM<=RUN.
  - Redirect overrides i_stall.
  - Redirect clears HALTED, because a HLT fetched behind a taken branch is speculative.
- Stall (no redirect): PC, o_instr, o_pc, o_valid and o_fetchCnt hold. The FSM holds.
- Normal, FSM=RUN, i_imData[15:12]!=HLT_OP: o_instr<=i_imData, o_pc<=PC+1, o_valid<=1, PC<=PC+1.
- Normal, FSM=RUN, i_imData[15:12]==HLT_OP:
  - HLT is passed to ID as a valid instruction: o_instr<=i_imData, o_valid<=1, o_pc<=PC+1.
  - PC does not advance.
  - FSM<=HALTED, o_halted<=1.
- FSM=HALTED, no redirect: PC holds, o_instr<=NOP_INSTR, o_valid<=0.
- o_fetchCnt increments by 1, wrapping, on every edge where o_valid is loaded with 1.
- FSM states:
  - RUN -> HALTED on an unstalled, unredirected HLT fetch.
  - HALTED -> RUN only on redirect.
  - Reset forces RUN.
- o_imAddr=PC combinationally at all times, including in HALTED.
- Latency: instruction at address A appears on o_instr one cycle after PC=A, absent stall.
- Flush costs exactly one bubble per redirect.

Test Plan:
- Reset release, imem[0..3]=16'h1123,16'h2234,16'h3345,16'h4456, no stall: o_instr sequence 1123,2234,3345,4456 on cycles 1-4; o_pc 1,2,3,4; o_fetchCnt=4.
- i_stall=1 for 2 cycles after PC=2: o_imAddr stays 2, o_instr holds 2234 for 3 cycles, o_fetchCnt unchanged; then 3345 follows.
- i_brTaken=1, i_brTarget=16'h0040, and i_jmp=1, i_jmpTarget=16'h0080 in the same cycle with i_stall=1:
  - next cycle PC=0040, o_valid=0, o_instr=0000;
  - following cycle o_instr=imem[0x40].
- imem[5]=16'hF000: after HLT delivered with o_valid=1, o_halted=1, PC stays 5, o_valid=0 for 10 cycles, o_fetchCnt frozen.
  - Then i_jmp to 16'h0010: o_halted=0, fetch resumes at 0x10.
- PC=16'hFFFF, imem[FFFF]=16'h1000: o_pc=0000, next PC=0000.
- Assert i_nRst=0 asynchronously mid-cycle while HALTED: all outputs reset immediately; fetch restarts at RESET_PC after release.
